// File: rtl/dcache_responder_if.sv
// dcache_responder_if: core request/hit bus plus single-word memory handshake
//   req_*      core access (valid, store, byte, address, store data)
//   hit/rdata  completion and load data back to the core
//   mem_*      request/ack handshake to main memory (writeback or fill)
interface dcache_responder_if;
   logic        req_valid;
   logic        req_we;
   logic        req_byte;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        hit;
   logic [31:0] rdata;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   modport master (
      output req_valid, req_we, req_byte, req_addr, req_wdata, mem_rdata, mem_ack,
      input  hit, rdata, mem_req, mem_we, mem_addr, mem_wdata
   );
   modport slave (
      input  req_valid, req_we, req_byte, req_addr, req_wdata, mem_rdata, mem_ack,
      output hit, rdata, mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/dcache_responder.sv
// dcache_responder: direct-mapped write-back write-allocate data cache, one word per line
//   clk, rst_b  clock and asynchronous active-low reset
//   bus         slave side of the core request bus and memory handshake
//   hit_cnt     accesses that hit on first try; miss_cnt misses detected
module dcache_responder #(
   parameter int IDX_W = 4
) (
   input  logic                clk,
   input  logic                rst_b,
   dcache_responder_if.slave   bus,
   output logic [31:0]         hit_cnt,
   output logic [31:0]         miss_cnt
);
   localparam int TAG_W = 30 - IDX_W;
   localparam int LINES = 2**IDX_W;
   typedef enum logic [1:0] {IDLE, WB, FILL, RESUME} state_t;
   state_t             state, state_nxt;
   logic [31:0]        data [LINES];
   logic [TAG_W-1:0]   tags [LINES];
   logic [LINES-1:0]   valid, dirty;
   logic [IDX_W-1:0]   idx, miss_idx;
   logic [TAG_W-1:0]   tag, miss_tag;
   logic [1:0]         off;
   logic [31:0]        line, merged;
   logic [7:0]         lane;
   logic               hit, miss, retry;
   logic               mem_req, mem_we;
   logic [31:0]        mem_addr, mem_wdata;
   assign idx = bus.req_addr[IDX_W+1:2];
   assign tag = bus.req_addr[31:IDX_W+2];
   assign off = bus.req_addr[1:0];
   assign line = data[idx];
   assign bus.hit = hit;
   assign bus.mem_req = mem_req;
   assign bus.mem_we = mem_we;
   assign bus.mem_addr = mem_addr;
   assign bus.mem_wdata = mem_wdata;
   always_ff @(posedge clk or negedge rst_b)
      if (!rst_b) state <= IDLE;
      else state <= state_nxt;
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = miss ? ((valid[idx] && dirty[idx]) ? WB : FILL) : IDLE;
         WB:      state_nxt = bus.mem_ack ? FILL : WB;
         FILL:    state_nxt = bus.mem_ack ? RESUME : FILL;
         default: state_nxt = IDLE;
      endcase
   end
   always_comb begin
      hit = state == IDLE && bus.req_valid && valid[idx] && tags[idx] == tag;
      miss = state == IDLE && bus.req_valid && !hit;
      lane = line[{off, 3'b000} +: 8];
      bus.rdata = !hit ? 32'h0 : bus.req_byte ? {24'h0, lane} : line;
      merged = bus.req_wdata;
      if (bus.req_byte) begin
         merged = line;
         merged[{off, 3'b000} +: 8] = bus.req_wdata[7:0];
      end
   end
   // retry marks the first IDLE cycle after a fill, whose hit is not a first-try hit
   always_ff @(posedge clk or negedge rst_b)
      if (!rst_b) begin
         valid <= '0;
         dirty <= '0;
         mem_req <= 1'b0;
         mem_we <= 1'b0;
         mem_addr <= '0;
         mem_wdata <= '0;
         miss_idx <= '0;
         miss_tag <= '0;
         retry <= 1'b0;
         hit_cnt <= '0;
         miss_cnt <= '0;
      end else begin
         retry <= state == RESUME;
         if (hit && !retry) hit_cnt <= hit_cnt + 32'd1;
         if (hit && bus.req_we) dirty[idx] <= 1'b1;
         case (state)
            IDLE: if (miss) begin
               miss_idx <= idx;
               miss_tag <= tag;
               miss_cnt <= miss_cnt + 32'd1;
               mem_req <= 1'b1;
               if (valid[idx] && dirty[idx]) begin
                  mem_we <= 1'b1;
                  mem_addr <= {tags[idx], idx, 2'b00};
                  mem_wdata <= line;
               end else begin
                  mem_we <= 1'b0;
                  mem_addr <= {tag, idx, 2'b00};
               end
            end
            WB: if (bus.mem_ack) begin
               dirty[miss_idx] <= 1'b0;
               mem_we <= 1'b0;
               mem_addr <= {miss_tag, miss_idx, 2'b00};
            end
            FILL: if (bus.mem_ack) begin
               valid[miss_idx] <= 1'b1;
               dirty[miss_idx] <= 1'b0;
               mem_req <= 1'b0;
            end
            default: ;
         endcase
      end
   always_ff @(posedge clk) begin
      if (hit && bus.req_we) data[idx] <= merged;
      if (state == FILL && bus.mem_ack) begin
         data[miss_idx] <= bus.mem_rdata;
         tags[miss_idx] <= miss_tag;
      end
   end
endmodule

// File: tb/tb_dcache_responder.sv
// tb_dcache_responder: directed scoreboard bench for dcache_responder
module tb_dcache_responder;
   logic        clk = 1'b0;
   logic        rst_b = 1'b0;
   logic [31:0] hit_cnt, miss_cnt;
   int          checks = 0;
   int          failures = 0;
   int          n;
   logic [31:0] exp_q[$];
   dcache_responder_if bus();
   dcache_responder #(.IDX_W(4)) dut (
      .clk(clk),
      .rst_b(rst_b),
      .bus(bus),
      .hit_cnt(hit_cnt),
      .miss_cnt(miss_cnt)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic req(input logic we, input logic byt, input logic [31:0] addr, input logic [31:0] wdata);
      bus.req_valid = 1'b1;
      bus.req_we = we;
      bus.req_byte = byt;
      bus.req_addr = addr;
      bus.req_wdata = wdata;
   endtask
   task automatic load(input logic byt, input logic [31:0] addr, input logic [31:0] exp);
      req(1'b0, byt, addr, 32'h0);
      exp_q.push_back(exp);
   endtask
   task automatic wait_hit(input string tag, input int budget, output int cyc);
      cyc = 0;
      forever begin
         @(negedge clk);
         if (bus.hit) break;
         if (cyc == budget) begin
            chk({tag, "_hit"}, {31'h0, bus.hit}, 32'h1);
            step();
            return;
         end
         step();
         cyc++;
      end
      if (!bus.req_we) chk({tag, "_rdata"}, bus.rdata, exp_q.pop_front());
      step();
   endtask
   task automatic service(input string tag, input int budget, input logic we,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rd);
      int k = 0;
      @(negedge clk);
      while (!bus.mem_req && k < budget) begin
         step();
         @(negedge clk);
         k++;
      end
      chk({tag, "_req"}, {31'h0, bus.mem_req}, 32'h1);
      chk({tag, "_we"}, {31'h0, bus.mem_we}, {31'h0, we});
      chk({tag, "_addr"}, bus.mem_addr, addr);
      if (we) chk({tag, "_wdata"}, bus.mem_wdata, wdata);
      bus.mem_rdata = rd;
      bus.mem_ack = 1'b1;
      step();
      bus.mem_ack = 1'b0;
   endtask
   initial begin
      bus.req_valid = 1'b0;
      bus.req_we = 1'b0;
      bus.req_byte = 1'b0;
      bus.req_addr = 32'h0;
      bus.req_wdata = 32'h0;
      bus.mem_ack = 1'b0;
      bus.mem_rdata = 32'h0;
      repeat (2) step();
      @(negedge clk);
      chk("rst_hit", {31'h0, bus.hit}, 32'h0);
      chk("rst_mem_req", {31'h0, bus.mem_req}, 32'h0);
      chk("rst_mem_addr", bus.mem_addr, 32'h0);
      chk("rst_hit_cnt", hit_cnt, 32'h0);
      chk("rst_miss_cnt", miss_cnt, 32'h0);
      step();
      rst_b = 1'b1;
      // cold miss on LW 0x10
      load(1'b0, 32'h10, 32'hDEADBEEF);
      @(negedge clk);
      chk("lw10_first_hit", {31'h0, bus.hit}, 32'h0);
      step();
      service("fill10", 0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF);
      chk("miss_cnt_1", miss_cnt, 32'h1);
      wait_hit("lw10", 4, n);
      chk("lw10_latency", n, 32'h1);
      chk("hit_cnt_after_retry", hit_cnt, 32'h0);
      // store/load hits, byte lanes
      req(1'b1, 1'b0, 32'h10, 32'h12345678);
      wait_hit("sw10", 0, n);
      chk("sw10_no_mem_req", {31'h0, bus.mem_req}, 32'h0);
      load(1'b0, 32'h10, 32'h12345678);
      wait_hit("lw10_b", 0, n);
      chk("hit_cnt_2", hit_cnt, 32'h2);
      req(1'b1, 1'b1, 32'h13, 32'hFFFFFFAA);
      wait_hit("sb13", 0, n);
      load(1'b1, 32'h13, 32'h000000AA);
      wait_hit("lb13", 0, n);
      load(1'b1, 32'h10, 32'h00000078);
      wait_hit("lb10", 0, n);
      load(1'b0, 32'h10, 32'hAA345678);
      wait_hit("lw10_c", 0, n);
      chk("hit_cnt_6", hit_cnt, 32'h6);
      // dirty conflict: writeback 0x10 then fill 0x50
      load(1'b0, 32'h50, 32'hCAFEF00D);
      @(negedge clk);
      chk("lw50_first_hit", {31'h0, bus.hit}, 32'h0);
      step();
      service("wb10", 0, 1'b1, 32'h10, 32'hAA345678, 32'hBAD0BAD0);
      for (int i = 0; i < 20; i++) begin
         bus.req_addr = 32'h90 + 32'(i * 4);
         @(negedge clk);
         chk("hold_mem_req", {31'h0, bus.mem_req}, 32'h1);
         chk("hold_mem_addr", bus.mem_addr, 32'h50);
         chk("hold_hit", {31'h0, bus.hit}, 32'h0);
         step();
      end
      bus.req_addr = 32'h50;
      service("fill50", 0, 1'b0, 32'h50, 32'h0, 32'hCAFEF00D);
      wait_hit("lw50", 4, n);
      chk("miss_cnt_2", miss_cnt, 32'h2);
      // clean victim goes straight to fill; reset abandons it
      req(1'b0, 1'b0, 32'h10, 32'h0);
      @(negedge clk);
      step();
      @(negedge clk);
      chk("clean_req", {31'h0, bus.mem_req}, 32'h1);
      chk("clean_we", {31'h0, bus.mem_we}, 32'h0);
      chk("clean_addr", bus.mem_addr, 32'h10);
      chk("miss_cnt_3", miss_cnt, 32'h3);
      rst_b = 1'b0;
      #1;
      chk("rst_drop_req", {31'h0, bus.mem_req}, 32'h0);
      chk("rst_mid_hit_cnt", hit_cnt, 32'h0);
      chk("rst_mid_miss_cnt", miss_cnt, 32'h0);
      step();
      step();
      rst_b = 1'b1;
      exp_q.push_back(32'h22222222);
      @(negedge clk);
      chk("post_rst_hit", {31'h0, bus.hit}, 32'h0);
      step();
      service("fill10_r", 0, 1'b0, 32'h10, 32'h0, 32'h22222222);
      chk("post_rst_miss_cnt", miss_cnt, 32'h1);
      wait_hit("lw10_r", 4, n);
      chk("post_rst_hit_cnt", hit_cnt, 32'h0);
      // stray ack in IDLE is ignored
      bus.req_valid = 1'b0;
      bus.mem_rdata = 32'h33333333;
      bus.mem_ack = 1'b1;
      step();
      bus.mem_ack = 1'b0;
      @(negedge clk);
      chk("stray_mem_req", {31'h0, bus.mem_req}, 32'h0);
      step();
      load(1'b0, 32'h10, 32'h22222222);
      wait_hit("lw10_stray", 0, n);
      chk("hit_cnt_stray", hit_cnt, 32'h1);
      // req_valid dropped mid-miss: fill still completes
      req(1'b0, 1'b0, 32'h94, 32'h0);
      @(negedge clk);
      step();
      bus.req_valid = 1'b0;
      service("fill94", 0, 1'b0, 32'h94, 32'h0, 32'h44332211);
      step();
      step();
      @(negedge clk);
      chk("dropped_hit", {31'h0, bus.hit}, 32'h0);
      step();
      load(1'b0, 32'h94, 32'h44332211);
      wait_hit("lw94", 0, n);
      load(1'b1, 32'h95, 32'h00000022);
      wait_hit("lb95", 0, n);
      load(1'b1, 32'h96, 32'h00000033);
      wait_hit("lb96", 0, n);
      chk("miss_cnt_end", miss_cnt, 32'h2);
      chk("hit_cnt_end", hit_cnt, 32'h4);
      bus.req_valid = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
